// File: rtl/door_if.sv
// Signal bundle between the elevator controller and the door sequencer.
interface door_if;
  logic       arrive;
  logic       stopped;
  logic       openBtn;
  logic       closeBtn;
  logic       obstruct;
  logic [1:0] dispStage;
  logic       doorClosed;

  modport master (
    output arrive, stopped, openBtn, closeBtn, obstruct,
    input  dispStage, doorClosed
  );

  modport slave (
    input  arrive, stopped, openBtn, closeBtn, obstruct,
    output dispStage, doorClosed
  );
endinterface

// File: rtl/door_seq.sv
// Door sequencer: steps the door open through four indicator stages, holds it,
// closes it again, and reverses a closing door on obstruction or open requests.
module door_seq #(
  parameter int STEP_TICKS = 4,
  parameter int HOLD_STEPS = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  door_if.slave  bus
);

  localparam int TW = $clog2(STEP_TICKS) + 1;
  localparam int HW = $clog2(HOLD_STEPS) + 1;

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      stage_q, stage_d;
  logic [TW-1:0]   tcnt_q,  tcnt_d;
  logic [HW-1:0]   hcnt_q,  hcnt_d;

  logic stepHit;
  logic reopenReq;

  assign stepHit   = (tcnt_q == TW'(STEP_TICKS - 1));
  assign reopenReq = bus.openBtn | bus.obstruct | bus.arrive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLOSED;
      stage_q <= 2'b00;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // The step timer free-runs and wraps on each step; entries and reversals clear it.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = stepHit ? '0 : tcnt_q + TW'(1);

    unique case (state_q)
      CLOSED: begin
        stage_d = 2'b00;
        tcnt_d  = '0;
        hcnt_d  = '0;
        if (bus.arrive || (bus.openBtn && bus.stopped)) begin
          state_d = OPENING;
        end
      end

      OPENING: begin
        if (stepHit) begin
          if (stage_q >= 2'b10) begin
            stage_d = 2'b11;
            state_d = OPEN_HOLD;
            hcnt_d  = '0;
          end else begin
            stage_d = stage_q + 2'b01;
          end
        end
      end

      OPEN_HOLD: begin
        stage_d = 2'b11;
        if (reopenReq) begin
          hcnt_d = '0;
          tcnt_d = '0;
        end else if (bus.closeBtn) begin
          state_d = CLOSING;
          tcnt_d  = '0;
        end else if (stepHit) begin
          if (hcnt_q == HW'(HOLD_STEPS - 1)) begin
            state_d = CLOSING;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end

      CLOSING: begin
        // A reversal keeps the current stage and reopens from there.
        if (reopenReq) begin
          state_d = OPENING;
          tcnt_d  = '0;
        end else if (stepHit) begin
          if (stage_q <= 2'b01) begin
            stage_d = 2'b00;
            state_d = CLOSED;
          end else begin
            stage_d = stage_q - 2'b01;
          end
        end
      end

      default: begin
        state_d = CLOSED;
        stage_d = 2'b00;
        tcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  assign bus.dispStage  = stage_q;
  assign bus.doorClosed = (state_q == CLOSED);

endmodule

// File: tb/tb_door_seq.sv
// Directed bench for door_seq with STEP_TICKS=4, HOLD_STEPS=3; cycle 0 is the trigger cycle.
`timescale 1ns/1ps
module tb_door_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  door_if dif ();

  door_seq #(.STEP_TICKS(4), .HOLD_STEPS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic applyStimulus(input logic arr, input logic stp, input logic ob,
                               input logic cb, input logic obs);
    dif.arrive   = arr;
    dif.stopped  = stp;
    dif.openBtn  = ob;
    dif.closeBtn = cb;
    dif.obstruct = obs;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expStage,
                             input logic expClosed);
    checks++;
    assert (dif.dispStage === expStage && dif.doorClosed === expClosed)
    else begin
      failures++;
      $error("[TB] FAIL %s: dispStage=%b doorClosed=%b, expected dispStage=%b doorClosed=%b",
             tag, dif.dispStage, dif.doorClosed, expStage, expClosed);
    end
  endtask

  // Issue a one-cycle arrive pulse; afterwards cyc counts from that trigger cycle.
  task automatic pulseArrive();
    cyc = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_state", 2'b00, 1'b1);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_after_reset", 2'b00, 1'b1);

    // Full open/hold/close cycle
    pulseArrive();
    checkOutput("t2_c1", 2'b00, 1'b0);
    waitTo(4);  checkOutput("t2_c4",  2'b00, 1'b0);
    waitTo(5);  checkOutput("t2_c5",  2'b01, 1'b0);
    waitTo(9);  checkOutput("t2_c9",  2'b10, 1'b0);
    waitTo(12); checkOutput("t2_c12", 2'b10, 1'b0);
    waitTo(13); checkOutput("t2_c13", 2'b11, 1'b0);
    waitTo(28); checkOutput("t2_c28", 2'b11, 1'b0);
    waitTo(29); checkOutput("t2_c29", 2'b10, 1'b0);
    waitTo(33); checkOutput("t2_c33", 2'b01, 1'b0);
    waitTo(36); checkOutput("t2_c36", 2'b01, 1'b0);
    waitTo(37); checkOutput("t2_c37", 2'b00, 1'b1);
    waitTo(45); checkOutput("t2_idle", 2'b00, 1'b1);

    // Obstruction reverses a closing door at stage 01
    pulseArrive();
    waitTo(34);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("t3_c35", 2'b01, 1'b0);
    waitTo(38); checkOutput("t3_c38", 2'b01, 1'b0);
    waitTo(39); checkOutput("t3_c39", 2'b10, 1'b0);
    waitTo(43); checkOutput("t3_c43", 2'b11, 1'b0);
    waitTo(60); checkOutput("t3_held", 2'b11, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitTo(75); checkOutput("t3_c75", 2'b11, 1'b0);
    waitTo(76); checkOutput("t3_c76", 2'b10, 1'b0);
    waitTo(84); checkOutput("t3_c84", 2'b00, 1'b1);

    // closeBtn during hold starts closing early
    pulseArrive();
    waitTo(15);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_c16", 2'b11, 1'b0);
    waitTo(19); checkOutput("t4_c19", 2'b11, 1'b0);
    waitTo(20); checkOutput("t4_c20", 2'b10, 1'b0);
    waitTo(28); checkOutput("t4_c28", 2'b00, 1'b1);

    // closeBtn together with openBtn only restarts the hold
    pulseArrive();
    waitTo(15);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitTo(20); checkOutput("t4b_c20", 2'b11, 1'b0);
    waitTo(31); checkOutput("t4b_c31", 2'b11, 1'b0);
    waitTo(32); checkOutput("t4b_c32", 2'b10, 1'b0);
    waitTo(40); checkOutput("t4b_c40", 2'b00, 1'b1);

    // openBtn is qualified by stopped while closed
    cyc = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    waitTo(20); checkOutput("t5_not_stopped", 2'b00, 1'b1);
    cyc = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_c1", 2'b00, 1'b0);
    waitTo(5);  checkOutput("t5_c5", 2'b01, 1'b0);
    waitTo(10); checkOutput("t6_c10_pre", 2'b10, 1'b0);

    // Asynchronous reset mid-opening, no clock edge needed
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset", 2'b00, 1'b1);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    waitTo(20); checkOutput("t6_no_motion", 2'b00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
